mem_slot_scheduler: RTL and testbench
=====================================

# mem_slot_scheduler

Time-slot scheduler that shares the single asynchronous cellular RAM between two playback tracks and one record stream. On every sample tick it runs one frame of up to three fixed-length RAM accesses: read track 0, read track 1, then write the record sample. It then publishes the saturated mix of the tracks it read. It sits between the sample-rate pulse generator, the recorder front end and the RAM pins, and owns all RAM control strobes.

## Interface
- ADDR_W, 21, per-track sample position width
- ACCESS_CYCLES, 7, active strobe cycles per RAM access (≥2)
- POS_WRAP, 2048000, position after which playback/record wraps to 0
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle frame start strobe (~32 kHz)
- play_en  in  2  per-track playback enable, sampled at frame start
- rec_en  in  1  record enable, sampled at frame start
- rec_track  in  1  track written by record slot, sampled at frame start
- pos_clear  in  1  rewind position to 0
- rec_data  in  16  record sample; rec_valid/rec_ready handshake
- rec_valid  in  1  record sample available
- rec_ready  out  1  one-cycle pulse: rec_data consumed this cycle
- mem_din  in  16  RAM data bus input
- mem_dout  out  16  RAM data bus output; mem_dout_oe  out  1  drive enable for the bus
- mem_addr  out  23  {1'b0, track, position}
- mem_adv_n, mem_clk, mem_cs_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n  out  1 each  RAM strobes
- mix_out  out  16  signed saturated track sum; mix_valid  out  1  one-cycle pulse when mix_out updates
- position  out  ADDR_W  current sample index
- overrun  out  1  one-cycle pulse: tick arrived while a frame was busy

## Operation
- States: IDLE, RD0, RD1, WR, RECOV, DONE. All outputs are registered.
- Reset values: all _n strobes 1, mem_clk 0, mem_dout_oe 0, mem_addr 0, mem_dout 0, rec_ready 0, mix_out 0, mix_valid 0, position 0, overrun 0, state IDLE.
- Tick handling:
  - IDLE + sample_tick: latch play_en/rec_en/rec_track; go to the first enabled slot in order RD0, RD1, WR.
  - If no slot is enabled, go straight to DONE.
- WR slot conditions:
  - WR is enabled only when rec_en=1 and rec_valid=1 at WR entry.
  - On entry, rec_ready pulses, rec_data is captured into mem_dout and held for the slot.
  - rec_en=1 with rec_valid=0: WR is skipped and no write occurs.
- Slot timing: each slot asserts its strobes for ACCESS_CYCLES cycles, then one RECOV cycle with all strobes inactive, then the next enabled slot or DONE.
- Read strobes: cs_n=0, oe_n=0, we_n=1, lb_n=ub_n=0, adv_n=0, mem_clk=0.
- Read capture: mem_din is captured into that track's register on the last active cycle. A disabled track's register is 0 for this frame.
- Write strobes: cs_n=0, we_n=0, oe_n=1, lb_n=ub_n=0, adv_n=0, mem_dout_oe=1 for all active cycles. mem_dout_oe=0 in every other state.
- Addressing: mem_addr = {0, slot track, position}. WR uses rec_track.
- Same-track collision: reads precede the write in a frame, so overdub playback returns the pre-write sample.
- DONE:
  - mix_out = signed(trk0) + signed(trk1), saturated to 0x7FFF / 0x8000.
  - mix_valid=1.
  - position updates: 0 if pos_clear was seen during the frame or is high now; else 0 if position == POS_WRAP; else position+1.
  - Return to IDLE.
- pos_clear in IDLE: position <= 0 next cycle.
- sample_tick outside IDLE: tick is ignored and overrun pulses next cycle. The frame and position are unaffected.

## Timing
- Tick sampled at edge k. The first slot's strobes are active in cycles k+1..k+ACCESS_CYCLES, followed by RECOV.
- Frame length = 1 + n_slots·(ACCESS_CYCLES+1) cycles, ending in DONE. mix_valid is high in cycle k + n_slots·(ACCESS_CYCLES+1) + 1.
- Latency with defaults:
  - all three slots: mix_valid at k+25
  - one slot: k+9
  - no slots: k+1
- A tick in the DONE cycle counts as overrun. A tick in the IDLE cycle after DONE starts a new frame.
- rst_n low at any point: strobes go inactive and mem_dout_oe=0 immediately (asynchronously). The interrupted access is abandoned and position returns to 0.

## Test plan
- Reset, then tick with play_en=01, RAM model at addr 0 = 0x1234 -> RD0 strobes in cycles 1..7, mix_out=0x1234 with mix_valid at cycle 9, position=1.
- play_en=11, track0=0x7000, track1=0x2000 -> mix_out=0x7FFF (saturated). Track0=0x8000, track1=0xFFFF -> mix_out=0x8000.
- rec_en=1, rec_track=1, rec_valid=1, rec_data=0xBEEF, play_en=10 -> read of track1 precedes the write. rec_ready pulses once. RAM at {0,1,pos} = 0xBEEF afterwards. mix returns the old value.
- rec_en=1 with rec_valid=0 -> no WE strobe, rec_ready stays 0, frame ends after the reads only.
- Force position=2047999 then tick -> position=2048000. Next tick -> position=0. pos_clear mid-frame -> position=0 at DONE.
- Second tick at k+5 -> overrun pulse at k+6, single mix_valid. rst_n low at k+4 -> strobes inactive in the same cycle, all outputs at reset values.

Source files
------------

// File: rtl/mem_slot_scheduler.sv
// Time-slot arbiter for the shared cellular RAM: per sample tick it reads up to
// two playback tracks, writes one record sample, then publishes the saturated mix.
module mem_slot_scheduler #(
  parameter int ADDR_W        = 21,
  parameter int ACCESS_CYCLES = 7,
  parameter int POS_WRAP      = 2048000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic [1:0]        play_en,
  input  logic              rec_en,
  input  logic              rec_track,
  input  logic              pos_clear,
  input  logic [15:0]       rec_data,
  input  logic              rec_valid,
  output logic              rec_ready,
  input  logic [15:0]       mem_din,
  output logic [15:0]       mem_dout,
  output logic              mem_dout_oe,
  output logic [ADDR_W+1:0] mem_addr,
  output logic              mem_adv_n,
  output logic              mem_clk,
  output logic              mem_cs_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_lb_n,
  output logic              mem_ub_n,
  output logic [15:0]       mix_out,
  output logic              mix_valid,
  output logic [ADDR_W-1:0] position,
  output logic              overrun
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR, RECOV, DONE} state_e;

  // First enabled slot at or after slot index 'from' (0=RD0, 1=RD1, 2=WR, 3=none).
  function automatic state_e pickSlot(input logic [1:0] from, input logic [1:0] pe,
                                      input logic wrOk);
    if (from == 2'd0 && pe[0]) return RD0;
    if (from <= 2'd1 && pe[1]) return RD1;
    if (from <= 2'd2 && wrOk) return WR;
    return DONE;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        slot_q, slotIdx_d;
  logic [1:0]        play_q;
  logic              rec_q, track_q, clear_q;
  logic [15:0]       trk0_q, trk1_q;
  logic [15:0]       mem_dout_q, mix_out_q;
  logic [ADDR_W+1:0] mem_addr_q;
  logic [ADDR_W-1:0] position_q, position_d;
  logic              cs_n_q, oe_n_q, we_n_q, dout_oe_q;
  logic              rec_ready_q, mix_valid_q, overrun_q;
  logic              lastCycle, isSlot_d, entering, entryTrack;
  logic [16:0]       sum;
  logic [15:0]       mixSat;

  always_comb begin
    state_d    = state_q;
    lastCycle  = (cnt_q == LAST_CNT);
    unique case (state_q)
      IDLE:         if (sample_tick) state_d = pickSlot(2'd0, play_en, rec_en & rec_valid);
      RD0, RD1, WR: if (lastCycle) state_d = RECOV;
      RECOV:        state_d = pickSlot(slot_q + 2'd1, play_q, rec_q & rec_valid);
      DONE:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
    isSlot_d   = (state_d == RD0) || (state_d == RD1) || (state_d == WR);
    entering   = (state_d != state_q);
    slotIdx_d  = (state_d == RD0) ? 2'd0 : (state_d == RD1) ? 2'd1 : 2'd2;
    entryTrack = (state_d == RD0) ? 1'b0 : (state_d == RD1) ? 1'b1 :
                 (state_q == IDLE) ? rec_track : track_q;
    sum        = {trk0_q[15], trk0_q} + {trk1_q[15], trk1_q};
    mixSat     = (sum[16] ^ sum[15]) ? (sum[16] ? 16'h8000 : 16'h7FFF) : sum[15:0];
    if (clear_q || pos_clear || position_q == ADDR_W'(POS_WRAP)) position_d = '0;
    else position_d = position_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      play_q      <= '0;
      rec_q       <= 1'b0;
      track_q     <= 1'b0;
      clear_q     <= 1'b0;
      trk0_q      <= '0;
      trk1_q      <= '0;
      mem_dout_q  <= '0;
      mix_out_q   <= '0;
      mem_addr_q  <= '0;
      position_q  <= '0;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dout_oe_q   <= 1'b0;
      rec_ready_q <= 1'b0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= entering ? '0 : cnt_q + 1'b1;
      overrun_q   <= sample_tick && (state_q != IDLE);
      rec_ready_q <= 1'b0;
      mix_valid_q <= 1'b0;
      cs_n_q      <= !isSlot_d;
      oe_n_q      <= !((state_d == RD0) || (state_d == RD1));
      we_n_q      <= (state_d != WR);
      dout_oe_q   <= (state_d == WR);

      if (state_q == IDLE) begin
        if (pos_clear) position_q <= '0;
        if (sample_tick) begin
          play_q  <= play_en;
          rec_q   <= rec_en;
          track_q <= rec_track;
          clear_q <= pos_clear;
          trk0_q  <= '0;
          trk1_q  <= '0;
        end
      end else if (pos_clear) begin
        clear_q <= 1'b1;
      end

      if (state_q == RD0 && lastCycle) trk0_q <= mem_din;
      if (state_q == RD1 && lastCycle) trk1_q <= mem_din;

      if (entering && isSlot_d) begin
        mem_addr_q <= {1'b0, entryTrack, position_q};
        slot_q     <= slotIdx_d;
      end
      if (entering && state_d == WR) begin
        rec_ready_q <= 1'b1;
        mem_dout_q  <= rec_data;
      end

      // A frame with no slots skips the reads entirely, so its mix is silence.
      if (entering && state_d == DONE) begin
        mix_valid_q <= 1'b1;
        mix_out_q   <= (state_q == IDLE) ? 16'h0000 : mixSat;
        position_q  <= position_d;
      end
      if (state_q == DONE) clear_q <= 1'b0;
    end
  end

  assign rec_ready   = rec_ready_q;
  assign mem_dout    = mem_dout_q;
  assign mem_dout_oe = dout_oe_q;
  assign mem_addr    = mem_addr_q;
  assign mem_adv_n   = cs_n_q;
  assign mem_clk     = 1'b0;
  assign mem_cs_n    = cs_n_q;
  assign mem_oe_n    = oe_n_q;
  assign mem_we_n    = we_n_q;
  assign mem_lb_n    = cs_n_q;
  assign mem_ub_n    = cs_n_q;
  assign mix_out     = mix_out_q;
  assign mix_valid   = mix_valid_q;
  assign position    = position_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_mem_slot_scheduler.sv
// Directed bench for mem_slot_scheduler: RAM model plus a scoreboard of expected
// mix/position/latency per frame, checked when mix_valid pulses.
module tb_mem_slot_scheduler;
  localparam int ADDR_W = 21;
  localparam int AC     = 7;
  localparam int WRAP   = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_tick, rec_en, rec_track, pos_clear, rec_valid;
  logic [1:0]        play_en;
  logic [15:0]       rec_data, mem_din, mem_dout, mix_out;
  logic              rec_ready, mem_dout_oe, mix_valid, overrun;
  logic [ADDR_W+1:0] mem_addr;
  logic              mem_adv_n, mem_clk, mem_cs_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n;
  logic [ADDR_W-1:0] position;

  typedef struct {
    logic [15:0]       mix;
    logic [ADDR_W-1:0] pos;
    int                cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [15:0] ram [0:511];
  logic [8:0]  ramIdx;
  int cyc = 0, checks = 0, errors = 0;
  int rdCycles = 0, wrCycles = 0, recPulses = 0, ovPulses = 0, ovCyc = 0;
  int tickCyc, k2, r0, w0, p0, ov0;

  mem_slot_scheduler #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(AC), .POS_WRAP(WRAP)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .play_en(play_en),
    .rec_en(rec_en), .rec_track(rec_track), .pos_clear(pos_clear),
    .rec_data(rec_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_dout_oe(mem_dout_oe),
    .mem_addr(mem_addr), .mem_adv_n(mem_adv_n), .mem_clk(mem_clk),
    .mem_cs_n(mem_cs_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_lb_n(mem_lb_n), .mem_ub_n(mem_ub_n), .mix_out(mix_out),
    .mix_valid(mix_valid), .position(position), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ramIdx  = {mem_addr[ADDR_W], mem_addr[7:0]};
  assign mem_din = (!mem_cs_n && !mem_oe_n) ? ram[ramIdx] : 16'h0000;
  always @(posedge clk) if (!mem_cs_n && !mem_we_n) ram[ramIdx] = mem_dout;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus activity counters and the scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!mem_cs_n && !mem_oe_n) rdCycles++;
      if (!mem_cs_n && !mem_we_n) wrCycles++;
      if (rec_ready) recPulses++;
      if (overrun) begin ovPulses++; ovCyc = cyc; end
      if (mix_valid) begin
        checkOutput("sb_nonempty", 32'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          checkOutput("mix", 32'(mix_out), 32'(e.mix));
          checkOutput("pos", 32'(position), 32'(e.pos));
          checkOutput("latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] pe, input logic re, input logic rt,
                               input int nslots, input logic [15:0] expMix,
                               input logic [ADDR_W-1:0] expPos);
    play_en = pe; rec_en = re; rec_track = rt; sample_tick = 1'b1;
    @(posedge clk); #1;
    tickCyc = cyc;
    sbq.push_back('{mix: expMix, pos: expPos, cyc: tickCyc + nslots * (AC + 1)});
    sample_tick = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin @(posedge clk); n++; end
    checkOutput("frame_done", sbq.size(), 0);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
    rst_n = 1'b0; sample_tick = 0; play_en = 0; rec_en = 0; rec_track = 0;
    pos_clear = 0; rec_data = 0; rec_valid = 0;
    repeat (3) @(posedge clk); #1;
    checkOutput("rst_cs_n", mem_cs_n, 1);
    checkOutput("rst_we_n", mem_we_n, 1);
    checkOutput("rst_oe_n", mem_oe_n, 1);
    checkOutput("rst_dout_oe", mem_dout_oe, 0);
    checkOutput("rst_mix", 32'(mix_out), 0);
    checkOutput("rst_pos", 32'(position), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    ram[9'h000] = 16'h1234;
    r0 = rdCycles;
    applyStimulus(2'b01, 0, 0, 1, 16'h1234, 1);
    checkOutput("rd0_cs_n", mem_cs_n, 0);
    checkOutput("rd0_oe_n", mem_oe_n, 0);
    checkOutput("rd0_addr", 32'(mem_addr), 0);
    waitDone();
    checkOutput("rd0_cycles", rdCycles - r0, AC);

    ram[9'h001] = 16'h7000; ram[9'h101] = 16'h2000;
    applyStimulus(2'b11, 0, 0, 2, 16'h7FFF, 2);
    waitDone();
    ram[9'h002] = 16'h8000; ram[9'h102] = 16'hFFFF;
    applyStimulus(2'b11, 0, 0, 2, 16'h8000, 3);
    waitDone();

    ram[9'h103] = 16'h1111;
    rec_data = 16'hBEEF; rec_valid = 1'b1;
    p0 = recPulses; w0 = wrCycles;
    applyStimulus(2'b10, 1, 1, 2, 16'h1111, 4);
    waitDone();
    rec_valid = 1'b0;
    checkOutput("rec_ready_pulses", recPulses - p0, 1);
    checkOutput("wr_cycles", wrCycles - w0, AC);
    checkOutput("ram_written", 32'(ram[9'h103]), 32'hBEEF);

    ram[9'h004] = 16'h0042;
    p0 = recPulses; w0 = wrCycles;
    applyStimulus(2'b01, 1, 0, 1, 16'h0042, 5);
    waitDone();
    checkOutput("skip_rec_ready", recPulses - p0, 0);
    checkOutput("skip_wr_cycles", wrCycles - w0, 0);

    applyStimulus(2'b00, 0, 0, 0, 16'h0000, 6);
    waitDone();
    applyStimulus(2'b00, 0, 0, 0, 16'h0000, 0);
    waitDone();
    applyStimulus(2'b00, 0, 0, 0, 16'h0000, 1);
    waitDone();

    applyStimulus(2'b01, 0, 0, 1, 16'h7000, 0);
    repeat (3) @(posedge clk); #1;
    pos_clear = 1'b1;
    @(posedge clk); #1;
    pos_clear = 1'b0;
    waitDone();

    applyStimulus(2'b00, 0, 0, 0, 16'h0000, 1);
    waitDone();
    pos_clear = 1'b1;
    @(posedge clk); #1;
    pos_clear = 1'b0;
    checkOutput("idle_clear", 32'(position), 0);

    ov0 = ovPulses;
    applyStimulus(2'b01, 0, 0, 1, 16'h1234, 1);
    repeat (3) @(posedge clk); #1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    k2 = cyc;
    sample_tick = 1'b0;
    waitDone();
    checkOutput("overrun_pulses", ovPulses - ov0, 1);
    checkOutput("overrun_cycle", ovCyc, k2);

    rec_data = 16'hABCD; rec_valid = 1'b1;
    applyStimulus(2'b00, 1, 0, 1, 16'h0000, 2);
    repeat (2) @(posedge clk); #1;
    checkOutput("wr_active_we_n", mem_we_n, 0);
    checkOutput("wr_active_oe", mem_dout_oe, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_we_n", mem_we_n, 1);
    checkOutput("arst_cs_n", mem_cs_n, 1);
    checkOutput("arst_dout_oe", mem_dout_oe, 0);
    checkOutput("arst_pos", 32'(position), 0);
    checkOutput("arst_dout", 32'(mem_dout), 0);
    checkOutput("arst_rec_ready", rec_ready, 0);
    sbq.delete();
    rec_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(2'b01, 0, 0, 1, 16'h1234, 1);
    waitDone();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
